sha512_w_sched: RTL and testbench
=================================

# sha512_w_sched

SHA-512 message-schedule generator: loads one 1024-bit message block and streams W_0..W_79 to the compression-round datapath, one word per accepted handshake, with the matching round constant K_t alongside. It is the producer on the W/K inputs of the round logic, so the round never has to store or expand the block. A valid/ready handshake lets the round controller stall the stream.

## Interface
Parameters: none. Word width 64 and round count 80 are fixed by FIPS 180-4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  load block and begin; honoured only in IDLE
- block  in  1024  message block, big-endian words: M_0 = block[1023:960], M_15 = block[63:0]
- w_valid  out  1  W/K/t hold a valid schedule word
- w_ready  in  1  consumer accepts the current word
- w  out  64  W_t; 0 when w_valid=0
- k  out  64  K_t; 0 when w_valid=0
- t  out  7  round index 0..79; 0 when w_valid=0
- last  out  1  w_valid & (t==79)
- busy  out  1  state==RUN
- done  out  1  one-cycle pulse after W_79 is accepted

## Operation
- Storage: 16×64 window win[0..15], with win[i] = W_{t+i}; 7-bit counter cnt.
- States: IDLE, RUN.
- IDLE: w_valid=0. If start=1, then win[i] <= M_i, cnt <= 0, and the state moves to RUN.
- RUN: w_valid=1, w=win[0], k=K_ROM[cnt], t=cnt.
  - Handshake (w_valid & w_ready) with cnt<79: the window shifts (win[i] <= win[i+1] for i<15), win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0] mod 2^64, and cnt <= cnt+1.
  - Handshake with cnt==79: the state moves to IDLE and done <= 1. The window contents are don't-care.
  - No handshake: all state holds; w, k and t stay stable.
- σ0(x) = ROTR1(x) ^ ROTR8(x) ^ SHR7(x).
- σ1(x) = ROTR19(x) ^ ROTR61(x) ^ SHR6(x).
- All additions truncate to 64 bits, with no carry out.
- Expansion words computed after t=63 are never emitted; computing them is allowed and harmless.
- start while in RUN is ignored, and block is not sampled.
- start in the cycle done=1 is accepted, because the state is already IDLE. This gives a back-to-back block with one idle cycle between W_79 and the next W_0.
- rst has priority over every other input. It may be asserted mid-stream.

## Timing
- Reset values (cycle after rst=1): state IDLE, cnt=0, window all zero, w_valid=0, w=0, k=0, t=0, last=0, busy=0, done=0.
- start sampled at edge N: w_valid=1 and W_0 are visible from edge N+1.
- Throughput: one word per cycle while w_ready=1. With no stalls, 80 words take 80 cycles.
- Final handshake at edge M: done=1 and w_valid=0 during cycle M+1.
- w, k, t and last are combinational from registers only, with no input-to-output paths. The exceptions are w_valid and busy, which are also direct register outputs.
- The critical path is one 4-operand 64-bit addition plus the σ logic, all inside one cycle.

## Structure
- Shared package sha512_pkg holds:
  - WORD_W=64, ROUNDS=80
  - the K_ROM[0:79] constant array
  - sigma0/sigma1 functions (the lowercase schedule σ, distinct from the round Σ)
  - the state enum {IDLE, RUN}
- One sub-module is natural: sha512_k_rom, a combinational 7-bit index to 64-bit K lookup. It is reusable by the round controller.
- Everything else stays flat in sha512_w_sched.

## Test plan
- Block "abc" (M_0=0x6162638000000000, M_1..M_14=0, M_15=0x18), w_ready=1:
  - W_0=0x6162638000000000, W_15=0x18, W_16=0x6162638000000000, W_17=0x00030000000000C0
  - k=0x428a2f98d728ae22 at t=0 and 0x6c44198c4a475817 at t=79
  - last at t=79 only; done pulses exactly one cycle later
- Backpressure: deassert w_ready for 5 cycles at t=3 -> w, k and t are held stable (t=3, W_3) for 5 cycles; the stream then resumes at W_4 with the same final values as the unstalled run.
- Reset mid-stream: assert rst at t=40 -> next cycle w_valid=0, w=k=t=0, busy=0, no done pulse. A following start restarts from W_0.
- Start while busy: pulse start with a different block at t=10 -> ignored; W_11..W_79 match the original block.
- Back-to-back: assert start with "abc" in the done cycle -> W_0=0x6162638000000000 appears one cycle after done.
- Random blocks (≥100) with random w_ready -> all 80 W values match a reference model, and exactly 80 handshakes occur per start.

Source files
------------

// File: rtl/sha512_pkg.sv
// ============================================================================
// Module   : sha512_pkg
// Brief    : Shared SHA-512 constants, schedule sigma functions and state type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sha512_pkg;

    localparam int WORD_W = 64;
    localparam int ROUNDS = 80;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WORD_W-1:0] K_ROM [0:ROUNDS-1] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // Lowercase schedule sigmas: ROTR1^ROTR8^SHR7 and ROTR19^ROTR61^SHR6.
    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ {7'b0, x[63:7]};
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ {6'b0, x[63:6]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha512_k_rom.sv
// ============================================================================
// Module   : sha512_k_rom
// Brief    : Combinational round-constant lookup, index 0..79 to K_t.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sha512_k_rom
    import sha512_pkg::*;
(
    input  logic [6:0]        i_idx,
    output logic [WORD_W-1:0] o_k
);

    always_comb begin
        o_k = '0;
        if (i_idx < 7'(ROUNDS)) begin
            o_k = K_ROM[i_idx];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sha512_w_sched.sv
// ============================================================================
// Module   : sha512_w_sched
// Brief    : SHA-512 message schedule; streams W_t and K_t over valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sha512_w_sched
    import sha512_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1023:0]       block,
    output logic                w_valid,
    input  logic                w_ready,
    output logic [WORD_W-1:0]   w,
    output logic [WORD_W-1:0]   k,
    output logic [6:0]          t,
    output logic                last,
    output logic                busy,
    output logic                done
);

    localparam logic [6:0] c_LAST = 7'(ROUNDS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [6:0]          r_cnt;
    logic [WORD_W-1:0]   r_win [0:15];
    logic                r_done;

    logic                w_hs;
    logic                w_load;
    logic                w_shift;
    logic                w_fin;
    logic [WORD_W-1:0]   w_new;
    logic [WORD_W-1:0]   w_k;

    assign w_hs = (r_state == RUN) && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_hs) begin
                    if (r_cnt == c_LAST) begin
                        w_fin       = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
        endcase
    end

    // W_{t+16} from the window, which always holds W_t..W_{t+15}.
    assign w_new = sigma1(r_win[14]) + r_win[9] + sigma0(r_win[1]) + r_win[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_done <= w_fin;
            if (w_load) begin
                r_cnt <= '0;
                for (int i = 0; i < 16; i++) begin
                    r_win[i] <= block[WORD_W*(15-i) +: WORD_W];
                end
            end else if (w_shift) begin
                r_cnt <= r_cnt + 7'd1;
                for (int i = 0; i < 15; i++) begin
                    r_win[i] <= r_win[i+1];
                end
                r_win[15] <= w_new;
            end
        end
    end

    sha512_k_rom u_k_rom (
        .i_idx (r_cnt),
        .o_k   (w_k)
    );

    assign w_valid = (r_state == RUN);
    assign busy    = (r_state == RUN);
    assign w       = w_valid ? r_win[0] : '0;
    assign k       = w_valid ? w_k : '0;
    assign t       = w_valid ? r_cnt : '0;
    assign last    = w_valid && (r_cnt == c_LAST);
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sha512_w_sched.sv
// ============================================================================
// Module   : tb_sha512_w_sched
// Brief    : Scoreboard bench for sha512_w_sched against a FIPS-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sha512_w_sched;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1023:0] block;
    logic          w_valid;
    logic          w_ready;
    logic [63:0]   w;
    logic [63:0]   k;
    logic [6:0]    t;
    logic          last;
    logic          busy;
    logic          done;

    sha512_w_sched dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .block   (block),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w       (w),
        .k       (k),
        .t       (t),
        .last    (last),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] w;
        logic [63:0] k;
        logic [6:0]  t;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] kref  [0:79];
    logic [63:0] mw    [0:79];
    logic [63:0] cap_w [0:79];
    logic [63:0] cap_k [0:79];
    bit          mon_en    = 1'b0;
    bit          pend_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout/unexpected want event", nm);
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] ss0(input logic [63:0] x);
        return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] ss1(input logic [63:0] x);
        return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

    // K_t = first 64 fractional bits of cbrt(prime_t) = floor(cbrt(p * 2^192)) mod 2^64.
    function automatic logic [63:0] cube_k(input int p);
        logic [255:0] n, lo, hi, mid;
        n  = 256'(p) << 192;
        lo = '0;
        hi = 256'(1) << 72;
        while ((hi - lo) > 256'(1)) begin
            mid = (lo + hi) >> 1;
            if (mid * mid * mid <= n) lo = mid;
            else                      hi = mid;
        end
        return lo[63:0];
    endfunction

    task automatic build_kref();
        int p;
        int n;
        bit isp;
        p = 2;
        n = 0;
        while (n < 80) begin
            isp = 1'b1;
            for (int d = 2; d * d <= p; d++) if (p % d == 0) isp = 1'b0;
            if (isp) begin
                kref[n] = cube_k(p);
                n++;
            end
            p++;
        end
    endtask

    task automatic build_model(input logic [1023:0] blk);
        for (int i = 0; i < 16; i++) mw[i] = blk[64*(15-i) +: 64];
        for (int i = 16; i < 80; i++)
            mw[i] = ss1(mw[i-2]) + mw[i-7] + ss0(mw[i-15]) + mw[i-16];
    endtask

    function automatic logic [1023:0] rand_block();
        logic [1023:0] b;
        for (int j = 0; j < 32; j++) b[32*j +: 32] = $urandom();
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1023:0] blk);
        exp_t e;
        build_model(blk);
        for (int i = 0; i < 80; i++) begin
            e.w = mw[i];
            e.k = kref[i];
            e.t = 7'(i);
            exp_q.push_back(e);
        end
        block = blk;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n;
        for (n = 0; n < 600; n++) begin
            if (done) break;
            if (rnd) w_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        if (n == 600) fail_now("wait_done");
        chk("handshakes_80", 64'(exp_q.size()), 64'd0);
        w_ready = 1'b1;
    endtask

    task automatic wait_t(input int tv);
        int n;
        for (n = 0; n < 200; n++) begin
            if (w_valid && t == 7'(tv)) break;
            tick();
        end
        if (n == 200) fail_now("wait_t");
    endtask

    // Monitor: pops one expected word per handshake and tracks the done pulse.
    always @(negedge clk) begin
        exp_t e;
        bit   hs;
        if (mon_en) begin
            chk("done", 64'(done), 64'(pend_done));
            pend_done = 1'b0;
            hs = w_valid && w_ready && !rst;
            if (!w_valid)
                chk("idle_zero", w | k | 64'(t) | 64'(last), 64'd0);
            if (hs) begin
                if (exp_q.size() == 0) begin
                    fail_now("extra_handshake");
                end else begin
                    e = exp_q.pop_front();
                    chk("w", w, e.w);
                    chk("k", k, e.k);
                    chk("t", 64'(t), 64'(e.t));
                    chk("last", 64'(last), 64'(e.t == 7'd79));
                    cap_w[t] = w;
                    cap_k[t] = k;
                    pend_done = (e.t == 7'd79);
                end
            end
        end
    end

    initial begin
        logic [1023:0] abc;
        logic [1023:0] blk_a;
        abc = '0;
        abc[1023:960] = 64'h6162638000000000;
        abc[63:0]     = 64'h18;

        build_kref();
        rst = 1'b1;
        start = 1'b0;
        w_ready = 1'b1;
        block = '0;
        tick();
        tick();
        chk("rst_valid", 64'(w_valid), 64'd0);
        chk("rst_w", w, 64'd0);
        chk("rst_k", k, 64'd0);
        chk("rst_t", 64'(t), 64'd0);
        chk("rst_flags", 64'({last, busy, done}), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // "abc" unstalled
        issue(abc);
        chk("first_valid", 64'({w_valid, busy}), 64'd3);
        chk("first_w", w, 64'h6162638000000000);
        wait_done(1'b0);
        chk("abc_w0", cap_w[0], 64'h6162638000000000);
        chk("abc_w15", cap_w[15], 64'h18);
        chk("abc_w16", cap_w[16], 64'h6162638000000000);
        chk("abc_w17", cap_w[17], 64'h00030000000000C0);
        chk("abc_k0", cap_k[0], 64'h428a2f98d728ae22);
        chk("abc_k79", cap_k[79], 64'h6c44198c4a475817);
        tick();

        // Backpressure at t=3
        issue(abc);
        wait_t(3);
        w_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_w", w, mw[3]);
            chk("stall_k", k, kref[3]);
            chk("stall_t", 64'({w_valid, t}), 64'({1'b1, 7'd3}));
        end
        w_ready = 1'b1;
        wait_done(1'b0);
        tick();

        // Reset mid-stream at t=40
        issue(rand_block());
        wait_t(40);
        rst = 1'b1;
        tick();
        chk("mrst_valid", 64'({w_valid, busy}), 64'd0);
        chk("mrst_wkt", w | k | 64'(t), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        tick();
        tick();
        issue(abc);
        chk("restart_w0", w, 64'h6162638000000000);
        wait_done(1'b0);
        tick();

        // Start while busy is ignored
        blk_a = rand_block();
        issue(blk_a);
        wait_t(10);
        block = rand_block();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0);

        // Back-to-back: start in the done cycle
        issue(abc);
        chk("b2b_w0", w, 64'h6162638000000000);
        chk("b2b_t0", 64'({w_valid, t}), 64'({1'b1, 7'd0}));
        wait_done(1'b0);

        // Random blocks with random backpressure
        for (int r = 0; r < 100; r++) begin
            issue(rand_block());
            wait_done(1'b1);
            if ($urandom_range(0, 1) == 1) tick();
        end

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
